// File: rtl/lsu_ctrl.sv
// Load/store unit: issues byte-enabled word accesses to a synchronous-read memory and returns one completion per request.
// Define LSU_MISALIGN_SPLIT_EN to split boundary-crossing accesses; otherwise misaligned accesses complete with resp_err.
module lsu_ctrl #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-3:0] mem_addr,
   output logic [3:0]            mem_be,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
   localparam bit SPLIT_EN = 1'b1;
`else
   localparam bit SPLIT_EN = 1'b0;
`endif

   localparam logic [ADDR_WIDTH-3:0] WORD_ONE = 1;

   typedef enum logic [1:0] {IDLE, A0, A1, DONE} state_t;

   // Handshake: a request transfers on a rising edge where req_valid and req_ready are both high.
   state_t      state;
   logic [1:0]  off_q;
   logic [2:0]  funct3_q;
   logic        we_q;
   logic        split_q;
   logic [3:0]  be_hi_q;
   logic [31:0] wdata_hi_q;
   logic [31:0] word0_q;

   logic [1:0]  req_off;
   logic [7:0]  req_base;
   logic [7:0]  req_mask8;
   logic [63:0] req_wide;
   logic        req_illegal;
   logic        req_misalign;

   assign req_off = req_addr[1:0];

   always_comb begin
      req_base = 8'h0F;
      case (req_funct3[1:0])
         2'd0:    req_base = 8'h01;
         2'd1:    req_base = 8'h03;
         default: req_base = 8'h0F;
      endcase
   end

   assign req_mask8   = req_base << req_off;
   assign req_wide    = {32'b0, req_wdata} << {req_off, 3'b000};
   assign req_illegal = req_we ? (req_funct3[2] | (&req_funct3[1:0]))
                               : ((&req_funct3[1:0]) | (req_funct3 == 3'd6));
   assign req_misalign = !SPLIT_EN &&
                         (((req_funct3[1:0] == 2'd1) && req_off[0]) ||
                          ((req_funct3[1:0] == 2'd2) && (req_off != 2'd0)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_be     <= '0;
         mem_wdata  <= '0;
         off_q      <= '0;
         funct3_q   <= '0;
         we_q       <= 1'b0;
         split_q    <= 1'b0;
         be_hi_q    <= '0;
         wdata_hi_q <= '0;
         word0_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_ready  <= 1'b0;
                  off_q      <= req_off;
                  funct3_q   <= req_funct3;
                  we_q       <= req_we;
                  split_q    <= |req_mask8[7:4];
                  be_hi_q    <= req_we ? req_mask8[7:4] : 4'b0;
                  wdata_hi_q <= req_we ? req_wide[63:32] : 32'b0;
                  if (req_illegal || req_misalign) begin
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     state      <= DONE;
                  end else begin
                     mem_req   <= 1'b1;
                     mem_we    <= req_we;
                     mem_addr  <= req_addr[ADDR_WIDTH-1:2];
                     mem_be    <= req_we ? req_mask8[3:0] : 4'b0;
                     mem_wdata <= req_we ? req_wide[31:0] : 32'b0;
                     state     <= A0;
                  end
               end
            end
            A0: begin
               if (SPLIT_EN && split_q) begin
                  mem_addr  <= mem_addr + WORD_ONE;
                  mem_be    <= be_hi_q;
                  mem_wdata <= wdata_hi_q;
                  state     <= A1;
               end else begin
                  mem_req    <= 1'b0;
                  mem_we     <= 1'b0;
                  mem_be     <= '0;
                  mem_wdata  <= '0;
                  resp_valid <= 1'b1;
                  state      <= DONE;
               end
            end
            A1: begin
               word0_q    <= mem_rdata;
               mem_req    <= 1'b0;
               mem_we     <= 1'b0;
               mem_be     <= '0;
               mem_wdata  <= '0;
               resp_valid <= 1'b1;
               state      <= DONE;
            end
            default: begin
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               req_ready  <= 1'b1;
               state      <= IDLE;
            end
         endcase
      end
   end

   // Read data arrives the cycle after the last access, so the final word is taken straight from mem_rdata.
   logic [63:0] raw64;
   logic [31:0] raw;

   assign raw64 = split_q ? {mem_rdata, word0_q} : {32'b0, mem_rdata};
   assign raw   = 32'(raw64 >> {off_q, 3'b000});

   always_comb begin
      resp_rdata = '0;
      if ((state == DONE) && !resp_err && !we_q) begin
         case (funct3_q)
            3'd0:    resp_rdata = {{24{raw[7]}}, raw[7:0]};
            3'd1:    resp_rdata = {{16{raw[15]}}, raw[15:0]};
            3'd4:    resp_rdata = {24'b0, raw[7:0]};
            3'd5:    resp_rdata = {16'b0, raw[15:0]};
            default: resp_rdata = raw;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-level reference model drives a per-cycle expected queue checked on every falling edge.
// Split-access tests are selected by LSU_MISALIGN_SPLIT_EN, matching the RTL build.
module tb_lsu_ctrl;

`ifdef LSU_MISALIGN_SPLIT_EN
   localparam bit SPLIT_EN = 1'b1;
`else
   localparam bit SPLIT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_req;
   logic        mem_we;
   logic [29:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'b0;

   always #5 clk = ~clk;

   lsu_ctrl #(.ADDR_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   typedef struct packed {
      logic        rdy;
      logic        mreq;
      logic        mwe;
      logic [29:0] maddr;
      logic [3:0]  mbe;
      logic [31:0] mwd;
      logic        rv;
      logic        rerr;
      logic [31:0] rd;
   } cyc_t;
   localparam int CYC_W = $bits(cyc_t);

   logic [CYC_W-1:0] exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   bit    chk_en = 1'b0;
   logic [31:0] last_rd = '0;
   logic        last_err = 1'b0;
   int    resp_cyc = 0;
   int    resp_cnt = 0;
   logic [29:0] log_addr[$];
   logic [3:0]  log_be[$];
   logic [31:0] log_wd[$];

   // Environment memory (16 words, aliased) and reference byte memory (64 bytes, same aliasing).
   logic [31:0] ram [16] = '{0: 32'hDDCC_BBAA, 1: 32'h4433_2211, default: 32'h0};
   logic [7:0]  ref_mem [64] = '{0: 8'hAA, 1: 8'hBB, 2: 8'hCC, 3: 8'hDD,
                                 4: 8'h11, 5: 8'h22, 6: 8'h33, 7: 8'h44, default: 8'h00};

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (mem_req) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_be[b]) ram[mem_addr[3:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
         end else begin
            mem_rdata <= ram[mem_addr[3:0]];
         end
      end
   end

   // Compare process
   always @(negedge clk) begin : cmp
      cyc_t e;
      if (rst_n && chk_en) begin
         e = '0;
         e.rdy = 1'b1;
         if (exp_q.size() > 0) e = cyc_t'(exp_q.pop_front());
         checks++;
         if (req_ready !== e.rdy || mem_req !== e.mreq || resp_valid !== e.rv ||
             resp_err !== e.rerr || resp_rdata !== e.rd ||
             (e.mreq && (mem_we !== e.mwe || mem_addr !== e.maddr ||
                         mem_be !== e.mbe || mem_wdata !== e.mwd)) ||
             (!mem_we && (mem_be !== 4'b0 || mem_wdata !== 32'b0))) begin
            errors++;
            $display("FAIL cycle_%0d got rdy=%b req=%b we=%b addr=%h be=%b wd=%h rv=%b err=%b rd=%h want rdy=%b req=%b we=%b addr=%h be=%b wd=%h rv=%b err=%b rd=%h",
                     cyc, req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                     resp_valid, resp_err, resp_rdata, e.rdy, e.mreq, e.mwe,
                     e.maddr, e.mbe, e.mwd, e.rv, e.rerr, e.rd);
         end
      end
      if (rst_n) begin
         if (resp_valid) begin
            last_rd  = resp_rdata;
            last_err = resp_err;
            resp_cyc = cyc;
            resp_cnt++;
         end
         if (mem_req) begin
            log_addr.push_back(mem_addr);
            log_be.push_back(mem_be);
            log_wd.push_back(mem_wdata);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, want);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_ctl"}, {23'b0, req_ready, resp_valid, resp_err, mem_req, mem_we, mem_be},
          32'h0000_0100);
      chk({tag, "_rdata"}, resp_rdata, 32'h0);
      chk({tag, "_addr"}, {2'b0, mem_addr}, 32'h0);
      chk({tag, "_wdata"}, mem_wdata, 32'h0);
   endtask

   // Reference model: byte-by-byte view of the access, produces the expected cycle sequence.
   task automatic model_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd);
      logic [31:0] a, val, rd;
      logic [29:0] w0, wl, w;
      logic [3:0]  be;
      logic [31:0] wdv;
      int n, nw, sv;
      bit legal;
      cyc_t c;
      legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
      n = 1 << f3[1:0];
      if (legal && !SPLIT_EN && (addr % n) != 0) legal = 1'b0;
      if (!legal) begin
         c = '0; c.rv = 1'b1; c.rerr = 1'b1;
         exp_q.push_back(CYC_W'(c));
         return;
      end
      w0 = addr[31:2];
      a  = addr + n - 1;
      wl = a[31:2];
      nw = (w0 == wl) ? 1 : 2;
      for (int k = 0; k < nw; k++) begin
         w = w0 + 30'(k);
         be = '0; wdv = '0;
         for (int i = 0; i < n; i++) begin
            a = addr + i;
            if (a[31:2] == w) begin
               be[a[1:0]] = 1'b1;
               wdv[8*a[1:0] +: 8] = wd[8*i +: 8];
            end
         end
         c = '0; c.mreq = 1'b1; c.mwe = we; c.maddr = w;
         c.mbe = we ? be : 4'b0;
         c.mwd = we ? wdv : 32'b0;
         exp_q.push_back(CYC_W'(c));
      end
      rd = '0;
      val = '0;
      for (int i = 0; i < n; i++) begin
         a = addr + i;
         if (we) ref_mem[a[5:0]] = wd[8*i +: 8];
         else val[8*i +: 8] = ref_mem[a[5:0]];
      end
      if (!we) begin
         rd = val;
         if (f3 == 3'd0) begin sv = $signed(val[7:0]);  rd = sv; end
         if (f3 == 3'd1) begin sv = $signed(val[15:0]); rd = sv; end
      end
      c = '0; c.rv = 1'b1; c.rd = rd;
      exp_q.push_back(CYC_W'(c));
   endtask

   task automatic drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (exp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout got %0d pending want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output int acc);
      int k = 0;
      @(negedge clk);
      while (!req_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!req_ready) begin
         checks++; errors++;
         $display("FAIL ready_timeout got 0 want 1");
      end
      log_addr.delete(); log_be.delete(); log_wd.delete();
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      acc = cyc;
      @(posedge clk);
      #1 req_valid = 1'b0;
      model_req(we, f3, addr, wd);
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got running want finished");
      $fatal(1);
   end

   initial begin
      int acc, rc0;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
      req_addr = '0; req_wdata = '0;
      repeat (2) @(negedge clk);
      chk_reset("reset");
      rst_n = 1'b1;
      chk_en = 1'b1;
      repeat (2) @(negedge clk);

      // Reset while the first store word is on the bus: no completion, nothing written.
      chk_en = 1'b0;
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20;
      req_wdata = 32'hDEAD_BEEF;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("abort_a0_memreq", {31'b0, mem_req}, 32'h1);
      rst_n = 1'b0;
      #1 chk_reset("abort");
      @(negedge clk);
      rst_n = 1'b1;
      rc0 = resp_cnt;
      chk_en = 1'b1;
      repeat (4) @(negedge clk);
      chk("abort_no_resp", resp_cnt, rc0);
      chk("abort_ready", {31'b0, req_ready}, 32'h1);
      do_req(1'b0, 3'd2, 32'h20, 32'h0, acc);
      chk("abort_unwritten", last_rd, 32'h0);

      if (SPLIT_EN) begin
         do_req(1'b0, 3'd2, 32'h3, 32'h0, acc);
         chk("split_lw_rd", last_rd, 32'h3322_11DD);
         chk("split_lw_lat", resp_cyc - acc, 3);
         chk("split_lw_a0", {2'b0, log_addr[0]}, 32'h0);
         chk("split_lw_a1", {2'b0, log_addr[1]}, 32'h1);
         do_req(1'b1, 3'd2, 32'hFFFF_FFFE, 32'h5566_7788, acc);
         chk("split_sw_a0", {2'b0, log_addr[0]}, 32'h3FFF_FFFF);
         chk("split_sw_be0", {28'b0, log_be[0]}, 32'hC);
         chk("split_sw_be1", {28'b0, log_be[1]}, 32'h3);
         chk("split_sw_a1", {2'b0, log_addr[1]}, 32'h0);
         do_req(1'b0, 3'd2, 32'h0, 32'h0, acc);
         chk("split_sw_word0", last_rd, 32'hDDCC_5566);
      end else begin
         do_req(1'b0, 3'd2, 32'h3, 32'h0, acc);
         chk("mis_lw_err", {31'b0, last_err}, 32'h1);
         chk("mis_lw_lat", resp_cyc - acc, 1);
         chk("mis_lw_nomem", log_addr.size(), 0);
         do_req(1'b0, 3'd1, 32'h1, 32'h0, acc);
         do_req(1'b1, 3'd1, 32'h3, 32'h1234, acc);
      end

      do_req(1'b1, 3'd0, 32'h6, 32'h0000_00A5, acc);
      chk("sb_be", {28'b0, log_be[0]}, 32'h4);
      chk("sb_wd", log_wd[0], 32'h00A5_0000);
      do_req(1'b0, 3'd0, 32'h6, 32'h0, acc);
      chk("lb_rd", last_rd, 32'hFFFF_FFA5);
      chk("lb_lat", resp_cyc - acc, 2);
      do_req(1'b0, 3'd4, 32'h6, 32'h0, acc);
      chk("lbu_rd", last_rd, 32'h0000_00A5);
      chk("lbu_lat", resp_cyc - acc, 2);

      do_req(1'b1, 3'd2, 32'h10, 32'h1122_3344, acc);
      do_req(1'b0, 3'd1, 32'h12, 32'h0, acc);
      chk("lh_rd", last_rd, 32'h0000_1122);
      do_req(1'b0, 3'd5, 32'h12, 32'h0, acc);
      chk("lhu_rd", last_rd, 32'h0000_1122);
      do_req(1'b0, 3'd2, 32'h10, 32'h0, acc);
      chk("lw_rd", last_rd, 32'h1122_3344);

      do_req(1'b1, 3'd3, 32'h10, 32'hFFFF_FFFF, acc);
      chk("st3_err", {31'b0, last_err}, 32'h1);
      chk("st3_lat", resp_cyc - acc, 1);
      chk("st3_nomem", log_addr.size(), 0);

      foreach (ref_mem[i]) begin end
      for (int f = 3; f < 8; f++) begin
         if (f == 3 || f == 6 || f == 7) do_req(1'b0, 3'(f), 32'h4, 32'h0, acc);
         if (f >= 4) do_req(1'b1, 3'(f), 32'h4, 32'h0, acc);
      end

      do_req(1'b0, 3'd1, 32'h10, 32'h0, acc);
      do_req(1'b0, 3'd0, 32'h13, 32'h0, acc);
      do_req(1'b0, 3'd5, 32'h2, 32'h0, acc);
      do_req(1'b0, 3'd1, 32'h2, 32'h0, acc);
      chk("lh_neg_rd", last_rd, 32'hFFFF_DDCC);
      do_req(1'b1, 3'd1, 32'h16, 32'h0000_BEEF, acc);
      do_req(1'b0, 3'd2, 32'h14, 32'h0, acc);
      chk("sh_lw_rd", last_rd, 32'hBEEF_0000);
      do_req(1'b0, 3'd1, 32'h7, 32'h0, acc);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

- Load/store unit; the initiator side of the data-memory interface.
- Accepts one RV32 load or store per handshake from the execute stage and issues word-aligned, byte-enabled accesses to a synchronous-read data memory.
- Assembles and sign/zero-extends load data and returns one completion per request.
- Sits between the core's memory stage and data memory. Splits boundary-crossing accesses into two word accesses when enabled.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width; memory word address is addr[ADDR_WIDTH-1:2].

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 funct3: lb/lh/lw/lbu/lhu, sb/sh/sw
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data (low bytes used per size)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  illegal funct3 or unsupported misalignment
- mem_req  out  1  memory access this cycle
- mem_we  out  1  write strobe qualifier
- mem_addr  out  ADDR_WIDTH-2  word address
- mem_be  out  4  byte enables (write lanes)
- mem_wdata  out  32  lane-aligned write data
- mem_rdata  in  32  read data, valid the cycle after mem_req with mem_we=0

## Operation
- States: IDLE, A0, A1, DONE.
- IDLE: req_ready=1. On req_valid, latch the request and decode.
  - Illegal: load funct3 in {3,6,7}, or store funct3 not in {0,1,2}. Go to DONE with err, no memory access.
  - Legal: go to A0.
- Size from funct3[1:0]: 0→1 byte, 1→2, 2→4. off = addr[1:0].
- Lane math:
  - mask8 = ((1<<size)-1) << off (8 bits).
  - wide = {32'b0, wdata} << 8*off (64 bits).
  - Word0 uses mask8[3:0] and wide[31:0]; word1 uses mask8[7:4] and wide[63:32].
  - cross = |mask8[7:4].
- A0: mem_req=1, mem_addr=addr[31:2], mem_we=req_we, mem_be=mask8[3:0] (stores; 0 for loads), mem_wdata=wide[31:0]. Next state: A1 if cross, else DONE.
- A1: captures word0 = mem_rdata. Drives word1 access: mem_addr = addr[31:2]+1, wrapping mod 2^(ADDR_WIDTH-2), with mask8[7:4] and wide[63:32]. Next state: DONE.
- DONE:
  - Captures the last read word: word1 if split, else word0.
  - raw = {word1, word0} >> 8*off; upper word treated as 0 when not split.
  - Extend per funct3:
    - lb / lh: sign-extend from bit 7 / bit 15.
    - lbu / lhu: zero-extend.
    - lw: raw[31:0].
  - resp_valid=1 for one cycle, then IDLE.
- Stores complete in their access cycle; resp_valid still follows in DONE with rdata=0.
- mem_req=0 in IDLE and DONE. mem_be=0 and mem_wdata=0 whenever mem_we=0.

## Timing
- Reset (async assert, sync release): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
- Accept at edge N:
  - Aligned or non-crossing: mem_req during N+1, resp_valid during N+2.
  - Split: accesses during N+1 and N+2, resp_valid during N+3.
  - Illegal: resp_valid during N+1, no mem_req.
- No response backpressure. Next accept is possible in the cycle after resp_valid (peak one aligned request per 3 cycles).
- req_valid while busy is ignored; the requester must hold it until req_ready.
- Reset mid-operation aborts: no resp_valid. A store word already written stays written; a pending second word is not issued.

## Configuration
- LSU_MISALIGN_SPLIT_EN defined: any alignment is legal; crossing accesses split as above.
- Undefined: any access not naturally aligned (lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]≠0) is an error.
  - The request goes IDLE→DONE with resp_err=1, rdata=0, no mem_req.
  - State A1 is unreachable.

## Test plan
- Reset mid-A0 of a store → no resp_valid; state IDLE; req_ready=1 after rst_n release.
- sb 0xA5 to 0x0000_0006, then lb and lbu at 0x6 → mem_be=0100, mem_wdata=0x00A5_0000; responses 0xFFFF_FFA5 and 0x0000_00A5, each 2 cycles after accept.
- sw 0x1122_3344 to 0x10, then lh/lhu at 0x12 → 0x0000_1122 for both; lw at 0x10 → 0x1122_3344.
- Store funct3=3 → resp_err=1 one cycle after accept, mem_req never asserted.
- LSU_MISALIGN_SPLIT_EN:
  - lw at 0x0000_0003 with words 0x0=0xDDCC_BBAA, 0x4=0x4433_2211 → mem_addr 0 then 1, resp 0x3322_11DD at N+3.
  - sw 0x5566_7788 at 0xFFFF_FFFE → be 1100 at word 0x3FFF_FFFF, then be 0011 at word 0.
- Without the macro: lw at 0x3 → resp_err=1 at N+1, no mem_req.
